// File: rtl/pyc_sync_mem_dp_arb_if.sv
// Request/response and memory-side bundle for pyc_sync_mem_dp_arb.
// The slave modport is the arbiter's view; the master modport is the clients plus the memory.
interface pyc_sync_mem_dp_arb_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NRD        = 4,
   parameter int unsigned NWR        = 2
);
   localparam int unsigned SW = DATA_WIDTH / 8;

   logic [NRD-1:0]            rd_valid;
   logic [NRD*ADDR_WIDTH-1:0] rd_addr;
   logic [NRD-1:0]            rd_ready;
   logic [NRD-1:0]            rsp_valid;
   logic [NRD*DATA_WIDTH-1:0] rsp_data;
   logic [NWR-1:0]            wr_valid;
   logic [NWR*ADDR_WIDTH-1:0] wr_addr;
   logic [NWR*DATA_WIDTH-1:0] wr_data;
   logic [NWR*SW-1:0]         wr_strb;
   logic [NWR-1:0]            wr_ready;
   logic                      mem_ren0;
   logic                      mem_ren1;
   logic [ADDR_WIDTH-1:0]     mem_raddr0;
   logic [ADDR_WIDTH-1:0]     mem_raddr1;
   logic [DATA_WIDTH-1:0]     mem_rdata0;
   logic [DATA_WIDTH-1:0]     mem_rdata1;
   logic                      mem_wvalid;
   logic [ADDR_WIDTH-1:0]     mem_waddr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [SW-1:0]             mem_wstrb;

   modport slave (
      input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_strb, mem_rdata0, mem_rdata1,
      output rd_ready, rsp_valid, rsp_data, wr_ready,
      output mem_ren0, mem_ren1, mem_raddr0, mem_raddr1,
      output mem_wvalid, mem_waddr, mem_wdata, mem_wstrb
   );

   modport master (
      output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_strb, mem_rdata0, mem_rdata1,
      input  rd_ready, rsp_valid, rsp_data, wr_ready,
      input  mem_ren0, mem_ren1, mem_raddr0, mem_raddr1,
      input  mem_wvalid, mem_waddr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/pyc_sync_mem_dp_arb.sv
// Round-robin scheduler sharing one 2R1W synchronous memory between NRD readers and NWR writers.
// Reads are tagged for one cycle so the registered memory data returns to its requester.
module pyc_sync_mem_dp_arb #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NRD        = 4,
   parameter int unsigned NWR        = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   pyc_sync_mem_dp_arb_if.slave bus
);
   localparam int unsigned SW  = DATA_WIDTH / 8;
   localparam int unsigned RPW = $clog2(NRD);
   localparam int unsigned WPW = (NWR > 1) ? $clog2(NWR) : 1;

   // run_q holds grants off until the first edge after reset release
   logic           run_q;
   logic [RPW-1:0] rd_ptr, rd_ptr_nxt;
   logic [WPW-1:0] wr_ptr, wr_ptr_nxt;
   logic           gnt0, gnt1, gntw;
   logic [RPW-1:0] gid0, gid1;
   logic [WPW-1:0] gidw;
   logic           tag_v0, tag_v1;
   logic [RPW-1:0] tag_id0, tag_id1;

   always_comb begin
      logic [RPW-1:0] idx;
      idx  = '0;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      gid0 = '0;
      gid1 = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         idx = RPW'((32'(rd_ptr) + k) % NRD);
         if (run_q && bus.rd_valid[idx]) begin
            if (!gnt0) begin
               gnt0 = 1'b1;
               gid0 = idx;
            end else if (!gnt1) begin
               gnt1 = 1'b1;
               gid1 = idx;
            end
         end
      end
   end

   always_comb begin
      logic [WPW-1:0] idx;
      idx  = '0;
      gntw = 1'b0;
      gidw = '0;
      for (int unsigned k = 0; k < NWR; k++) begin
         idx = WPW'((32'(wr_ptr) + k) % NWR);
         if (run_q && !gntw && bus.wr_valid[idx]) begin
            gntw = 1'b1;
            gidw = idx;
         end
      end
   end

   assign bus.mem_ren0   = gnt0;
   assign bus.mem_ren1   = gnt1;
   assign bus.mem_wvalid = gntw;

   always_comb begin
      bus.rd_ready   = '0;
      bus.mem_raddr0 = '0;
      bus.mem_raddr1 = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         if (gnt0 && gid0 == RPW'(i)) begin
            bus.rd_ready[i] = 1'b1;
            bus.mem_raddr0  = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
         if (gnt1 && gid1 == RPW'(i)) begin
            bus.rd_ready[i] = 1'b1;
            bus.mem_raddr1  = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_comb begin
      bus.wr_ready  = '0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      for (int unsigned i = 0; i < NWR; i++) begin
         if (gntw && gidw == WPW'(i)) begin
            bus.wr_ready[i] = 1'b1;
            bus.mem_waddr   = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_wdata   = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            bus.mem_wstrb   = bus.wr_strb[i*SW +: SW];
         end
      end
   end

   // Pointer moves past the last requester served this cycle
   always_comb begin
      logic [RPW-1:0] last;
      last       = gnt1 ? gid1 : gid0;
      rd_ptr_nxt = rd_ptr;
      if (gnt0) rd_ptr_nxt = (32'(last) == NRD - 1) ? '0 : last + 1'b1;
      wr_ptr_nxt = wr_ptr;
      if (gntw) wr_ptr_nxt = (32'(gidw) == NWR - 1) ? '0 : gidw + 1'b1;
   end

   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_data  = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         if (tag_v0 && tag_id0 == RPW'(i)) begin
            bus.rsp_valid[i]                        = 1'b1;
            bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata0;
         end
         if (tag_v1 && tag_id1 == RPW'(i)) begin
            bus.rsp_valid[i]                        = 1'b1;
            bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         tag_v0  <= 1'b0;
         tag_v1  <= 1'b0;
         tag_id0 <= '0;
         tag_id1 <= '0;
      end else begin
         run_q   <= 1'b1;
         rd_ptr  <= rd_ptr_nxt;
         wr_ptr  <= wr_ptr_nxt;
         tag_v0  <= gnt0;
         tag_v1  <= gnt1;
         tag_id0 <= gid0;
         tag_id1 <= gid1;
      end
   end
endmodule

// File: tb/tb_pyc_sync_mem_dp_arb.sv
// Bench for pyc_sync_mem_dp_arb: behavioural memory, a per-cycle reference model and directed vectors.
module tb_pyc_sync_mem_dp_arb;
   localparam int unsigned AW  = 64;
   localparam int unsigned DW  = 64;
   localparam int unsigned NRD = 4;
   localparam int unsigned NWR = 2;
   localparam int unsigned SW  = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   pyc_sync_mem_dp_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NRD(NRD), .NWR(NWR)) bus ();

   pyc_sync_mem_dp_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NRD(NRD), .NWR(NWR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fmem [logic [AW-1:0]];
   logic [DW-1:0] rmem [logic [AW-1:0]];

   function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [SW-1:0] s);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] fget(logic [AW-1:0] a);
      return fmem.exists(a) ? fmem[a] : '0;
   endfunction

   function automatic logic [DW-1:0] rget(logic [AW-1:0] a);
      return rmem.exists(a) ? rmem[a] : '0;
   endfunction

   task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   // 2R1W memory with registered read data and write-first forwarding
   always @(posedge clk) begin : fake_mem
      logic [DW-1:0] w;
      if (bus.mem_wvalid) begin
         w = merge(fget(bus.mem_waddr), bus.mem_wdata, bus.mem_wstrb);
         fmem[bus.mem_waddr] = w;
      end
      if (bus.mem_ren0) bus.mem_rdata0 <= fget(bus.mem_raddr0);
      if (bus.mem_ren1) bus.mem_rdata1 <= fget(bus.mem_raddr1);
   end

   // Reference model: rotation lists of valid requesters, pending responses per requester
   initial begin : model
      int            m_rd_ptr, m_wr_ptr, n_rd_ptr, n_wr_ptr, id, w;
      bit            m_run;
      bit            m_pv [NRD];
      bit            n_pv [NRD];
      logic [DW-1:0] m_pd [NRD];
      logic [DW-1:0] n_pd [NRD];
      int            order[$];
      int            worder[$];
      logic [NRD-1:0]    e_rdy, e_rv;
      logic [NRD*DW-1:0] e_rd;
      logic [NWR-1:0]    e_wrdy;
      logic              e_ren0, e_ren1, e_wv;
      logic [AW-1:0]     e_ra0, e_ra1, e_wa, a;
      logic [DW-1:0]     e_wd, d;
      logic [SW-1:0]     e_ws;
      m_run = 0;
      m_rd_ptr = 0;
      m_wr_ptr = 0;
      for (int i = 0; i < NRD; i++) begin m_pv[i] = 0; m_pd[i] = '0; end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_run = 0;
            for (int i = 0; i < NRD; i++) m_pv[i] = 0;
         end
         e_rv = '0;
         e_rd = '0;
         for (int i = 0; i < NRD; i++) if (m_pv[i]) begin e_rv[i] = 1'b1; e_rd[i*DW +: DW] = m_pd[i]; end
         n_rd_ptr = m_rd_ptr;
         n_wr_ptr = m_wr_ptr;
         for (int i = 0; i < NRD; i++) begin n_pv[i] = 0; n_pd[i] = '0; end
         e_rdy = '0; e_ren0 = 0; e_ren1 = 0; e_ra0 = '0; e_ra1 = '0;
         e_wrdy = '0; e_wv = 0; e_wa = '0; e_wd = '0; e_ws = '0;
         order.delete();
         worder.delete();
         if (rst_n && m_run) begin
            for (int k = 0; k < NWR; k++) begin
               id = (m_wr_ptr + k) % NWR;
               if (bus.wr_valid[id]) worder.push_back(id);
            end
            if (worder.size() > 0) begin
               w = worder[0];
               e_wrdy[w] = 1'b1;
               e_wv = 1'b1;
               e_wa = bus.wr_addr[w*AW +: AW];
               e_wd = bus.wr_data[w*DW +: DW];
               e_ws = bus.wr_strb[w*SW +: SW];
               n_wr_ptr = (w + 1) % NWR;
            end
            for (int k = 0; k < NRD; k++) begin
               id = (m_rd_ptr + k) % NRD;
               if (bus.rd_valid[id]) order.push_back(id);
            end
            for (int j = 0; j < order.size() && j < 2; j++) begin
               id = order[j];
               a = bus.rd_addr[id*AW +: AW];
               e_rdy[id] = 1'b1;
               if (j == 0) begin e_ren0 = 1'b1; e_ra0 = a; end
               else        begin e_ren1 = 1'b1; e_ra1 = a; end
               d = rget(a);
               if (e_wv && e_wa == a) d = merge(d, e_wd, e_ws);
               n_pv[id] = 1;
               n_pd[id] = d;
               n_rd_ptr = (id + 1) % NRD;
            end
         end
         check("m_rd_ready",   bus.rd_ready,   e_rdy);
         check("m_mem_ren0",   bus.mem_ren0,   e_ren0);
         check("m_mem_ren1",   bus.mem_ren1,   e_ren1);
         check("m_mem_raddr0", bus.mem_raddr0, e_ra0);
         check("m_mem_raddr1", bus.mem_raddr1, e_ra1);
         check("m_rsp_valid",  bus.rsp_valid,  e_rv);
         check("m_rsp_data",   bus.rsp_data,   e_rd);
         check("m_wr_ready",   bus.wr_ready,   e_wrdy);
         check("m_mem_wvalid", bus.mem_wvalid, e_wv);
         check("m_mem_waddr",  bus.mem_waddr,  e_wa);
         check("m_mem_wdata",  bus.mem_wdata,  e_wd);
         check("m_mem_wstrb",  bus.mem_wstrb,  e_ws);
         @(posedge clk);
         if (rst_n) begin
            m_run = 1;
            m_rd_ptr = n_rd_ptr;
            m_wr_ptr = n_wr_ptr;
            if (e_wv) rmem[e_wa] = merge(rget(e_wa), e_wd, e_ws);
            for (int i = 0; i < NRD; i++) begin m_pv[i] = n_pv[i]; m_pd[i] = n_pd[i]; end
         end else begin
            m_run = 0;
            m_rd_ptr = 0;
            m_wr_ptr = 0;
            for (int i = 0; i < NRD; i++) m_pv[i] = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(int id, logic [AW-1:0] a);
      bus.rd_valid[id] = 1'b1;
      bus.rd_addr[id*AW +: AW] = a;
   endtask

   task automatic set_wr(int id, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
      bus.wr_valid[id] = 1'b1;
      bus.wr_addr[id*AW +: AW] = a;
      bus.wr_data[id*DW +: DW] = d;
      bus.wr_strb[id*SW +: SW] = s;
   endtask

   task automatic all_rd();
      for (int i = 0; i < NRD; i++) set_rd(i, 64'h10 + 64'(i));
   endtask

   initial begin : stim
      bus.rd_valid = '1;
      bus.rd_addr  = '0;
      bus.wr_valid = '1;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.wr_strb  = '0;
      repeat (2) step();
      check("rst_rd_ready",  bus.rd_ready,   4'b0000);
      check("rst_wr_ready",  bus.wr_ready,   2'b00);
      check("rst_rsp_valid", bus.rsp_valid,  4'b0000);
      check("rst_mem_ren0",  bus.mem_ren0,   1'b0);
      check("rst_mem_wv",    bus.mem_wvalid, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rel_rd_ready", bus.rd_ready, 4'b0000);
      bus.rd_valid = '0;
      bus.wr_valid = '0;

      // preload through writer 1 only, leaving the write pointer at 0
      step();
      set_wr(1, 64'h5, 64'hAA, 8'hFF);
      #1;
      check("pre_wr_ready", bus.wr_ready, 2'b10);
      for (int i = 0; i < 4; i++) begin
         step();
         set_wr(1, 64'h10 + 64'(i), 64'hB0 + 64'(i), 8'hFF);
      end

      step();
      bus.wr_valid = '0;
      set_rd(2, 64'h5);
      #1;
      check("single_rd_ready", bus.rd_ready,   4'b0100);
      check("single_ren0",     bus.mem_ren0,   1'b1);
      check("single_raddr0",   bus.mem_raddr0, 64'h5);
      check("single_ren1",     bus.mem_ren1,   1'b0);

      step();
      bus.rd_valid = '0;
      set_rd(3, 64'h30);
      #1;
      check("single_rsp_valid", bus.rsp_valid, 4'b0100);
      check("single_rsp_d2",    bus.rsp_data[2*DW +: DW], 64'hAA);

      for (int c = 0; c < 4; c++) begin
         step();
         all_rd();
         #1;
         check("all_rd_ready", bus.rd_ready,   (c % 2 == 0) ? 4'b0011 : 4'b1100);
         check("all_raddr0",   bus.mem_raddr0, 64'h10 + 64'((c % 2) * 2));
         check("all_raddr1",   bus.mem_raddr1, 64'h11 + 64'((c % 2) * 2));
         if (c == 0) begin
            check("all_rsp_valid0", bus.rsp_valid, 4'b1000);
            check("all_rsp_d3z",    bus.rsp_data[3*DW +: DW], 64'h0);
         end else begin
            check("all_rsp_valid", bus.rsp_valid, (c % 2 == 1) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < NRD; i++)
               if (((c % 2 == 1) && i < 2) || ((c % 2 == 0) && i >= 2))
                  check("all_rsp_d", bus.rsp_data[i*DW +: DW], 64'hB0 + 64'(i));
         end
      end

      step();
      bus.rd_valid = '0;
      set_rd(2, 64'h40);
      #1;
      check("tail_rsp_valid", bus.rsp_valid, 4'b1100);
      check("tail_rsp_d2",    bus.rsp_data[2*DW +: DW], 64'hB2);
      check("tail_rsp_d3",    bus.rsp_data[3*DW +: DW], 64'hB3);
      check("tail_rd_ready",  bus.rd_ready,  4'b0100);

      step();
      bus.rd_valid = '0;
      set_rd(3, 64'h13);
      set_rd(0, 64'h10);
      #1;
      check("wrap_rd_ready", bus.rd_ready,   4'b1001);
      check("wrap_raddr0",   bus.mem_raddr0, 64'h13);
      check("wrap_raddr1",   bus.mem_raddr1, 64'h10);
      check("wrap_ren1",     bus.mem_ren1,   1'b1);

      step();
      all_rd();
      #1;
      check("wrap_ptr_ready", bus.rd_ready,   4'b0110);
      check("wrap_rsp_valid", bus.rsp_valid,  4'b1001);
      check("wrap_rsp_d3",    bus.rsp_data[3*DW +: DW], 64'hB3);
      check("wrap_rsp_d0",    bus.rsp_data[0*DW +: DW], 64'hB0);

      step();
      bus.rd_valid = '0;
      set_wr(0, 64'h7, 64'h11, 8'hFF);
      set_wr(1, 64'h8, 64'h22, 8'hFF);
      #1;
      check("wr_first_ready", bus.wr_ready,  2'b01);
      check("wr_first_addr",  bus.mem_waddr, 64'h7);
      check("wr_first_data",  bus.mem_wdata, 64'h11);

      step();
      set_rd(0, 64'h8);
      #1;
      check("wr_second_ready", bus.wr_ready,  2'b10);
      check("wr_second_addr",  bus.mem_waddr, 64'h8);
      check("wr_second_data",  bus.mem_wdata, 64'h22);
      check("fwd_rd_ready",    bus.rd_ready,  4'b0001);

      step();
      bus.rd_valid = '0;
      bus.wr_valid = '0;
      set_wr(0, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
      #1;
      check("fwd_rsp_valid", bus.rsp_valid, 4'b0001);
      check("fwd_rsp_d0",    bus.rsp_data[0*DW +: DW], 64'h22);
      check("strb_wr_ready", bus.wr_ready,  2'b01);
      check("strb_wstrb",    bus.mem_wstrb, 8'h01);

      step();
      bus.wr_valid = '0;
      set_rd(1, 64'h20);
      #1;
      check("strb_rd_ready", bus.rd_ready, 4'b0010);

      step();
      bus.rd_valid = '0;
      set_rd(0, 64'h10);
      set_rd(1, 64'h11);
      #1;
      check("strb_rsp_valid", bus.rsp_valid, 4'b0010);
      check("strb_rsp_d1",    bus.rsp_data[1*DW +: DW], 64'hFF);
      check("mid_rd_ready",   bus.rd_ready,  4'b0011);
      check("mid_raddr0",     bus.mem_raddr0, 64'h10);

      step();
      bus.rd_valid = '0;
      #1;
      check("mid_rsp_valid", bus.rsp_valid, 4'b0011);
      all_rd();
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", bus.rsp_valid, 4'b0000);
      check("mid_rst_rsp_data",  bus.rsp_data,  256'h0);
      check("mid_rst_rd_ready",  bus.rd_ready,  4'b0000);

      step();
      rst_n = 1'b1;
      #1;
      check("rel2_rd_ready", bus.rd_ready, 4'b0000);
      check("rel2_ren0",     bus.mem_ren0, 1'b0);

      step();
      #1;
      check("post_rd_ready", bus.rd_ready,   4'b0011);
      check("post_raddr0",   bus.mem_raddr0, 64'h10);
      check("post_raddr1",   bus.mem_raddr1, 64'h11);

      // mixed traffic from a fixed pattern table, checked cycle by cycle by the model
      for (int c = 0; c < 24; c++) begin
         step();
         bus.rd_valid = 4'((c * 7 + 3) % 16);
         for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = 64'h10 + 64'((c + i) % 4);
         bus.wr_valid = 2'(c % 4);
         for (int i = 0; i < NWR; i++) begin
            bus.wr_addr[i*AW +: AW] = 64'h10 + 64'((c + 2 * i) % 4);
            bus.wr_data[i*DW +: DW] = 64'h1000 + 64'(c * 16 + i);
            bus.wr_strb[i*SW +: SW] = 8'((c * 37 + i * 11) % 256);
         end
      end

      step();
      bus.rd_valid = '0;
      bus.wr_valid = '0;
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
